// File: rtl/acq_sequencer.sv
//------------------------------------------------------------------------------
// Module      : acq_sequencer
// Description : Acquisition master sequencer. On start it loads the AGC DAC
//               level over SPI, waits for the analog chain to settle, loads the
//               control word into both I/Q ADC interfaces and then enables
//               acquisition for a programmed sample count or until stopped.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acq_sequencer #(
   parameter int unsigned AGC_SETTLE   = 1000,
   parameter int unsigned CTRL_SETTLE  = 100,
   parameter int unsigned TIMEOUT      = 4096,
   parameter int unsigned CNT_W        = 32,
   parameter logic [11:0] AGC_DEFAULT  = 12'h555,
   parameter logic [9:0]  CTRL_DEFAULT = 10'b0000100100
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             start,
   input  logic             stop,
   input  logic [11:0]      cfg_agc,
   input  logic [9:0]       cfg_ctrlword,
   input  logic [CNT_W-1:0] cfg_nsamples,
   input  logic             agc_busy,
   input  logic             adc_mbusy_i,
   input  logic             adc_mbusy_q,
   input  logic             sample_valid,
   output logic [11:0]      agc_data,
   output logic             agc_load,
   output logic [9:0]       adc_ctrlword,
   output logic             adc_ldctrl,
   output logic             adc_enable,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] c_IDLE       = 3'd0;
   localparam logic [2:0] c_AGC_LOAD   = 3'd1;
   localparam logic [2:0] c_AGC_WAIT   = 3'd2;
   localparam logic [2:0] c_AGC_SETTLE = 3'd3;
   localparam logic [2:0] c_CFG_LOAD   = 3'd4;
   localparam logic [2:0] c_CFG_WAIT   = 3'd5;
   localparam logic [2:0] c_RUN        = 3'd6;
   localparam logic [2:0] c_STOP       = 3'd7;

   // One shared timer covers both the AGC settle and the control settle+timeout
   // window; it never has to count past the larger of the two.
   localparam int unsigned TW = $clog2(AGC_SETTLE + CTRL_SETTLE + TIMEOUT + 2);

   localparam logic [TW-1:0] c_AS_LAST = TW'(AGC_SETTLE - 1);
   localparam logic [TW-1:0] c_CS_LAST = TW'(CTRL_SETTLE - 1);
   localparam logic [TW-1:0] c_TO_LAST = TW'(CTRL_SETTLE + TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] nsamp_q, nsamp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      agc_q, agc_d;
   logic [9:0]       ctrl_q, ctrl_d;
   logic             err_q, err_d;
   logic             agc_load_q;
   logic             ldctrl_q;
   logic             enable_q;
   logic             busy_q;
   logic             done_q;

   // Next-state, timer, sample counter and configuration shadow logic.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      nsamp_d = nsamp_q;
      cnt_d   = cnt_q;
      agc_d   = agc_q;
      ctrl_d  = ctrl_q;
      err_d   = err_q;

      case (state_q)
         c_IDLE: begin
            // A start that coincides with stop is treated as cancelled.
            if (start && !stop) begin
               agc_d   = cfg_agc;
               ctrl_d  = cfg_ctrlword;
               nsamp_d = cfg_nsamples;
               cnt_d   = '0;
               err_d   = 1'b0;
               tmr_d   = '0;
               state_d = c_AGC_LOAD;
            end
         end
         c_AGC_LOAD: begin
            tmr_d   = '0;
            state_d = c_AGC_WAIT;
         end
         c_AGC_WAIT: begin
            // The first wait cycle is unconditional so the SPI master has time
            // to raise its busy flag before it is trusted.
            tmr_d = {{(TW-1){1'b0}}, 1'b1};
            if ((tmr_q != '0) && !agc_busy) begin
               tmr_d   = '0;
               state_d = c_AGC_SETTLE;
            end
         end
         c_AGC_SETTLE: begin
            if (tmr_q == c_AS_LAST) begin
               tmr_d   = '0;
               state_d = c_CFG_LOAD;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         c_CFG_LOAD: begin
            tmr_d   = '0;
            state_d = c_CFG_WAIT;
         end
         c_CFG_WAIT: begin
            // Both channels must be idle in the same cycle; a late release on
            // the very last timeout cycle still counts as success.
            if ((tmr_q >= c_CS_LAST) && !adc_mbusy_i && !adc_mbusy_q) begin
               state_d = c_RUN;
            end else if (tmr_q == c_TO_LAST) begin
               err_d   = 1'b1;
               state_d = c_STOP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         c_RUN: begin
            if (sample_valid) begin
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if ((nsamp_q != '0) && (cnt_d == nsamp_q)) begin
                  state_d = c_STOP;
               end
            end
         end
         c_STOP: begin
            state_d = c_IDLE;
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase

      // A host abort wins over every in-flight transition, including a
      // coincident control-load timeout.
      if (stop && (state_q != c_IDLE) && (state_q != c_STOP)) begin
         err_d   = err_q;
         state_d = c_STOP;
      end
   end

   // State, shadow registers and registered outputs.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q    <= c_IDLE;
         tmr_q      <= '0;
         nsamp_q    <= '0;
         cnt_q      <= '0;
         agc_q      <= AGC_DEFAULT;
         ctrl_q     <= CTRL_DEFAULT;
         err_q      <= 1'b0;
         agc_load_q <= 1'b0;
         ldctrl_q   <= 1'b0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         nsamp_q    <= nsamp_d;
         cnt_q      <= cnt_d;
         agc_q      <= agc_d;
         ctrl_q     <= ctrl_d;
         err_q      <= err_d;
         // Load pulses are issued on leaving the load states, so an abort
         // there still lets the pulse go out.
         agc_load_q <= (state_q == c_AGC_LOAD);
         ldctrl_q   <= (state_q == c_CFG_LOAD);
         enable_q   <= (state_d == c_RUN);
         busy_q     <= (state_d != c_IDLE);
         done_q     <= (state_d == c_STOP);
      end
   end

   assign agc_data     = agc_q;
   assign agc_load     = agc_load_q;
   assign adc_ctrlword = ctrl_q;
   assign adc_ldctrl   = ldctrl_q;
   assign adc_enable   = enable_q;
   assign sample_cnt   = cnt_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_acq_sequencer
// Description : Scoreboard bench for acq_sequencer. Each run plan is turned
//               into an expected list of output events (load pulses, enable
//               edges, done) computed from the sequencing rules by arithmetic;
//               a negedge monitor pops and compares them as the DUT emits them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acq_sequencer;

   localparam int AS  = 4;
   localparam int CS  = 8;
   localparam int TO  = 32;
   localparam int CW  = 8;
   localparam int BIG = 1 << 30;

   localparam int K_AGC  = 0;
   localparam int K_LDC  = 1;
   localparam int K_ENR  = 2;
   localparam int K_DONE = 3;
   localparam int K_EF   = 4;

   logic          clk = 1'b0;
   logic          arstn = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [11:0]   cfg_agc = '0;
   logic [9:0]    cfg_ctrlword = '0;
   logic [CW-1:0] cfg_nsamples = '0;
   logic          agc_busy = 1'b0;
   logic          adc_mbusy_i = 1'b0;
   logic          adc_mbusy_q = 1'b0;
   logic          sample_valid = 1'b0;
   logic [11:0]   agc_data;
   logic          agc_load;
   logic [9:0]    adc_ctrlword;
   logic          adc_ldctrl;
   logic          adc_enable;
   logic [CW-1:0] sample_cnt;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit prev_en = 1'b0;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] d;
   } ev_t;

   ev_t exq[$];

   acq_sequencer #(
      .AGC_SETTLE  (AS),
      .CTRL_SETTLE (CS),
      .TIMEOUT     (TO),
      .CNT_W       (CW),
      .AGC_DEFAULT (12'h555),
      .CTRL_DEFAULT(10'b0000100100)
   ) dut (
      .clk         (clk),
      .arstn       (arstn),
      .start       (start),
      .stop        (stop),
      .cfg_agc     (cfg_agc),
      .cfg_ctrlword(cfg_ctrlword),
      .cfg_nsamples(cfg_nsamples),
      .agc_busy    (agc_busy),
      .adc_mbusy_i (adc_mbusy_i),
      .adc_mbusy_q (adc_mbusy_q),
      .sample_valid(sample_valid),
      .agc_data    (agc_data),
      .agc_load    (agc_load),
      .adc_ctrlword(adc_ctrlword),
      .adc_ldctrl  (adc_ldctrl),
      .adc_enable  (adc_enable),
      .sample_cnt  (sample_cnt),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_AGC:   return "agc_load";
         K_LDC:   return "adc_ldctrl";
         K_ENR:   return "enable_rise";
         K_DONE:  return "done";
         default: return "enable_fall";
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [31:0] d);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.d    = d;
      exq.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [31:0] d);
      ev_t e;
      if (exq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected %s at cycle %0d data %h (nothing expected)", kname(kind), cyc, d);
      end else begin
         e = exq.pop_front();
         chk({"event kind (", kname(kind), ")"}, 32'(kind), 32'(e.kind));
         chk({kname(e.kind), " cycle"}, 32'(cyc), 32'(e.cyc));
         chk({kname(e.kind), " data"}, d, e.d);
      end
   endtask

   // Monitor: every output event the DUT presents is popped off the scoreboard.
   always @(negedge clk) begin
      if (agc_load)                check_ev(K_AGC, {19'b0, err, agc_data});
      if (adc_ldctrl)              check_ev(K_LDC, {22'b0, adc_ctrlword});
      if (adc_enable && !prev_en)  check_ev(K_ENR, {23'b0, busy, sample_cnt});
      if (done)                    check_ev(K_DONE, {21'b0, adc_enable, err, busy, sample_cnt});
      if (!adc_enable && prev_en)  check_ev(K_EF, 32'h0);
      prev_en = adc_enable;
   end

   logic [11:0] last_agc = 12'h555;
   int          last_cnt = 0;
   bit          last_err = 1'b0;

   // One acquisition run. Relative cycle r = 0 is the cycle after the edge
   // that samples start. agc_busy is high for B cycles from r=2; one mbusy
   // channel is high for M cycles from the adc_ldctrl cycle.
   task automatic run_plan(input int B, input int M, input bit mq, input int N,
                           input logic [11:0] agc, input logic [9:0] ctrl,
                           input int stop_at, input int dens, input int xs_in,
                           input int len);
      bit sv[];
      int E, L, R, cm, Xto, Xs, Xlim, X, cnt, xs;
      bit to, errx;
      sv = new[len];
      foreach (sv[i]) sv[i] = ($urandom_range(0, 99) < dens);
      E = cyc + 1;
      // adc_ldctrl: 1 load + 2 min wait + B extra busy cycles + settle + 1 cfg load
      L = 4 + B + AS;
      // RUN begins the edge after the first cycle that is past the control
      // settle time and has both mbusy low.
      cm = (L + CS - 1 > L + M) ? L + CS - 1 : L + M;
      R = cm + 1;
      to = (R > L + CS + TO);
      Xto = to ? L + CS + TO : BIG;
      if (to) R = BIG;
      Xs = stop_at + 1;
      Xlim = BIG;
      if (!to && N != 0) begin
         cnt = 0;
         for (int c = R; c < len && Xlim == BIG; c++) begin
            if (sv[c]) begin
               cnt++;
               if (cnt == N) Xlim = c + 1;
            end
         end
      end
      X = Xs;
      if (Xlim < X) X = Xlim;
      if (Xto < X) X = Xto;
      errx = to && (Xto < Xs);
      cnt = 0;
      for (int c = R; c < X; c++) if (sv[c]) cnt++;
      if (cnt > 255) cnt = 255;

      push(K_AGC, E + 1, {20'b0, agc});
      if (X >= L) push(K_LDC, E + L, {22'b0, ctrl});
      if (R < X)  push(K_ENR, E + R, 32'h100);
      push(K_DONE, E + X, {21'b0, 1'b0, errx, 1'b1, cnt[7:0]});
      if (R < X)  push(K_EF, E + X, 32'h0);
      xs = (xs_in >= 0) ? (xs_in % X) : -1;

      cfg_agc      = agc;
      cfg_ctrlword = ctrl;
      cfg_nsamples = CW'(N);
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
      cfg_agc      = 12'($urandom);
      cfg_ctrlword = 10'($urandom);
      cfg_nsamples = CW'($urandom);
      for (int r = 0; r < len; r++) begin
         agc_busy     = (r >= 2) && (r < 2 + B);
         adc_mbusy_q  = mq  && (r >= L) && (r < L + M);
         adc_mbusy_i  = !mq && (r >= L) && (r < L + M);
         sample_valid = sv[r];
         stop         = (r == stop_at);
         start        = (r == xs);
         @(posedge clk); #1;
      end
      agc_busy     = 1'b0;
      adc_mbusy_i  = 1'b0;
      adc_mbusy_q  = 1'b0;
      sample_valid = 1'b0;
      stop         = 1'b0;
      start        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle busy", 32'(busy), 32'h0);
      chk("idle err hold", 32'(err), 32'(errx));
      chk("idle sample_cnt hold", 32'(sample_cnt), 32'(cnt));
      chk("idle agc_data hold", 32'(agc_data), 32'(agc));
      chk("idle ctrlword hold", 32'(adc_ctrlword), 32'(ctrl));
      last_agc = agc;
      last_cnt = cnt;
      last_err = errx;
   endtask

   // start together with stop in IDLE must not launch a run; stray samples
   // in IDLE must not count.
   task automatic start_stop_idle();
      cfg_agc      = 12'h123;
      cfg_nsamples = CW'(3);
      start        = 1'b1;
      stop         = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
      stop         = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("start+stop busy", 32'(busy), 32'h0);
         chk("start+stop agc_data", 32'(agc_data), 32'(last_agc));
         chk("idle sample ignored", 32'(sample_cnt), 32'(last_cnt));
      end
      sample_valid = 1'b0;
   endtask

   // Asynchronous reset during RUN: enable drops at once, no done follows.
   task automatic reset_mid_run();
      int E;
      cfg_agc      = 12'h9A5;
      cfg_ctrlword = 10'h0F0;
      cfg_nsamples = '0;
      E = cyc + 1;
      push(K_AGC, E + 1, {20'b0, 12'h9A5});
      push(K_LDC, E + 8, {22'b0, 10'h0F0});
      push(K_ENR, E + 16, 32'h100);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int r = 0; r < 20; r++) begin
         sample_valid = (r >= 10);
         @(posedge clk); #1;
      end
      push(K_EF, cyc, 32'h0);
      #1 arstn = 1'b0;
      #1;
      chk("reset adc_enable", 32'(adc_enable), 32'h0);
      chk("reset agc_data", 32'(agc_data), 32'h555);
      chk("reset ctrlword", 32'(adc_ctrlword), 32'h024);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset sample_cnt", 32'(sample_cnt), 32'h0);
      sample_valid = 1'b0;
      @(posedge clk); #3;
      arstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post-reset idle busy", 32'(busy), 32'h0);
      end
      last_agc = 12'h555;
      last_cnt = 0;
      last_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst agc_data", 32'(agc_data), 32'h555);
      chk("rst adc_ctrlword", 32'(adc_ctrlword), 32'h024);
      chk("rst agc_load", 32'(agc_load), 32'h0);
      chk("rst adc_ldctrl", 32'(adc_ldctrl), 32'h0);
      chk("rst adc_enable", 32'(adc_enable), 32'h0);
      chk("rst sample_cnt", 32'(sample_cnt), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst err", 32'(err), 32'h0);
      arstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Nominal: ldctrl at +8, enable at +16, five samples then done.
      run_plan(0, 0, 1'b0, 5, 12'hABC, 10'h024, 79, 100, -1, 80);
      // Continuous: 20 samples then stop.
      run_plan(0, 0, 1'b0, 0, 12'h0F0, 10'h155, 35, 100, -1, 40);
      // AGC busy stretched for 10 cycles delays everything downstream.
      run_plan(10, 0, 1'b0, 3, 12'h777, 10'h2AA, 79, 60, -1, 80);
      // Q-channel mbusy stuck: timeout, err, no enable.
      run_plan(0, 60, 1'b1, 5, 12'h111, 10'h0C3, 79, 100, -1, 80);
      // Next start clears err; short I-channel busy inside the settle window.
      run_plan(0, 3, 1'b0, 4, 12'h222, 10'h301, 79, 100, -1, 80);
      // start during RUN is ignored.
      run_plan(0, 0, 1'b0, 6, 12'h333, 10'h045, 79, 50, 18, 80);
      // stop in AGC_WAIT: no ldctrl.
      run_plan(10, 0, 1'b0, 5, 12'h444, 10'h1F0, 5, 100, -1, 20);
      // mbusy released on the last timeout cycle still runs.
      run_plan(0, 39, 1'b1, 2, 12'h5A5, 10'h3C3, 79, 100, -1, 80);
      start_stop_idle();
      // Counter saturation in a long continuous run.
      run_plan(0, 0, 1'b0, 0, 12'h321, 10'h3FF, 290, 100, -1, 292);

      for (int i = 0; i < 25; i++) begin
         int B, M, N, sa, dens, xs;
         bit mq;
         B    = $urandom_range(0, 12);
         M    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(30, 50)) : int'($urandom_range(0, 12));
         mq   = 1'($urandom_range(0, 1));
         N    = $urandom_range(0, 20);
         dens = $urandom_range(30, 100);
         if (N == 0) sa = $urandom_range(20, 110);
         else        sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 119;
         xs   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1;
         run_plan(B, M, mq, N, 12'($urandom), 10'($urandom), sa, dens, xs, 120);
      end

      reset_mid_run();
      run_plan(0, 0, 1'b0, 5, 12'hABC, 10'h024, 79, 100, -1, 80);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard drained", 32'(exq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Acquisition master sequencer that replaces the free-running temporary sequencer in the top level. On a start request it:
- loads the AGC DAC level through the AGC SPI master;
- waits a programmable settle time;
- loads the control word into both I/Q ADC interfaces;
- enables acquisition for a programmable number of samples, or until stopped.

It reports progress, completion and control-load timeout to the host command path.

Parameters:
AGC_SETTLE, 1000, clk cycles to wait after the AGC SPI transfer completes
CTRL_SETTLE, 100, clk cycles between adc_ldctrl pulse and adc_enable assertion
TIMEOUT, 4096, max extra clk cycles to wait for both mbusy low after CTRL_SETTLE
CNT_W, 32, width of sample count and nsamples
AGC_DEFAULT, 12'h555, agc_data reset value (1 V RMS)
CTRL_DEFAULT, 10'b0000100100, adc_ctrlword reset value

Ports:
clk  in  1  system clock (PLL GLA)
arstn  in  1  async active-low reset
start  in  1  one-cycle start request
stop  in  1  one-cycle stop/abort request
cfg_agc  in  12  AGC DAC code, latched on accepted start
cfg_ctrlword  in  10  ADC control word, latched on accepted start
cfg_nsamples  in  CNT_W  samples to acquire; 0 = continuous
agc_busy  in  1  AGC SPI master busy (~csn)
adc_mbusy_i  in  1  I-channel ADC interface busy
adc_mbusy_q  in  1  Q-channel ADC interface busy
sample_valid  in  1  one-cycle pulse per I/Q sample pair written to FIFO
agc_data  out  12  AGC DAC code to SPI master
agc_load  out  1  one-cycle AGC transfer request
adc_ctrlword  out  10  control word to both ADC interfaces
adc_ldctrl  out  1  one-cycle control load pulse, both channels
adc_enable  out  1  acquisition enable, both channels
sample_cnt  out  CNT_W  samples counted in current run
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on return to IDLE
err  out  1  sticky mbusy timeout flag

Behaviour:
- Clocking and reset:
  - Reset: arstn is asynchronous, active-low; clock is clk.
  - Every output is registered.
  - Reset values: agc_data=AGC_DEFAULT, adc_ctrlword=CTRL_DEFAULT, all other outputs 0, state=IDLE.
- States: IDLE, AGC_LOAD, AGC_WAIT, AGC_SETTLE, CFG_LOAD, CFG_WAIT, RUN, STOP.
- IDLE:
  - start=1 and stop=0: latch cfg_* into agc_data, adc_ctrlword and a shadow nsamples; clear sample_cnt and err; go to AGC_LOAD.
  - start and stop in the same cycle: remain in IDLE.
- AGC_LOAD: agc_load=1 for exactly this cycle; go to AGC_WAIT.
- AGC_WAIT:
  - Minimum 2 cycles, which covers the SPI master busy-assertion latency.
  - Exits on the first subsequent cycle with agc_busy=0; go to AGC_SETTLE.
- AGC_SETTLE: counts AGC_SETTLE cycles; go to CFG_LOAD.
- CFG_LOAD: adc_ldctrl=1 for exactly one cycle; go to CFG_WAIT.
- CFG_WAIT:
  - Counts CTRL_SETTLE cycles, then waits for adc_mbusy_i=0 and adc_mbusy_q=0 in the same cycle, then goes to RUN.
  - If either mbusy is still high TIMEOUT cycles after CTRL_SETTLE expires: set err, go to STOP.
- Nominal latency: with agc_busy and mbusy held low, adc_enable rises 3+AGC_SETTLE+1+CTRL_SETTLE cycles after the edge that samples start.
- RUN:
  - adc_enable=1.
  - Each sample_valid increments sample_cnt; sample_cnt saturates at 2^CNT_W-1.
  - nsamples≠0 and the increment makes sample_cnt==nsamples: go to STOP. That sample is counted.
  - nsamples=0: runs until stop.
- STOP: adc_enable=0 from this cycle; done=1 for one cycle; go to IDLE.
- stop in any non-IDLE state except STOP: go to STOP next cycle.
  - stop in AGC_WAIT: the AGC SPI transfer is not cancelled and completes on its own.
  - stop in CFG_LOAD: the ldctrl pulse still issues.
- start while busy=1 is ignored.
- sample_valid outside RUN is ignored.
- sample_cnt, agc_data and adc_ctrlword hold their values in IDLE until the next accepted start.
- Asynchronous reset mid-run: adc_enable drops immediately; no done pulse.

Test Plan:
- Nominal run (AGC_SETTLE=4, CTRL_SETTLE=8, nsamples=5, cfg_agc=12'hABC, cfg_ctrlword=10'h024, busy inputs low, start at edge 0):
  - agc_load at cycle 1 with agc_data=ABC;
  - adc_ldctrl at cycle 8;
  - adc_enable rises at cycle 16;
  - after 5 sample_valid pulses, adc_enable falls, done pulses once, sample_cnt=5.
- Continuous run, nsamples=0, 20 sample_valid pulses, then stop -> adc_enable stays high through all 20; falls the cycle after stop; sample_cnt=20; done=1.
- AGC_WAIT handshake: agc_busy held high 10 cycles after agc_load -> AGC_SETTLE begins only after agc_busy drops; adc_ldctrl is delayed accordingly.
- mbusy timeout: adc_mbusy_q held high, TIMEOUT=32 -> err=1 exactly 32 cycles after CTRL_SETTLE expiry; adc_enable never asserts; done pulses; the next start clears err.
- start during RUN ignored; start+stop together in IDLE stays IDLE. Stop in AGC_WAIT -> STOP next cycle; no adc_ldctrl is issued.
- arstn low mid-RUN -> adc_enable=0 and agc_data=12'h555 asynchronously; state IDLE after release; no done pulse.
